video_cmd_controller: RTL and testbench

- Command controller between the UART receive path, the UART transmitter and the video pipeline.
- Parses short ASCII commands from received bytes and holds the requested test-pattern and display-byte settings in shadow registers.
- Commits the shadow settings to the active outputs only on a frame strobe, so video changes land on frame boundaries.
- Sends a one-byte acknowledge or query reply through the transmitter handshake.

---
 rtl/video_cmd_controller.sv | 207 ++++++++++++++++++++
 tb/tb_video_cmd_controller.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/video_cmd_controller.sv
// Command controller: parses ASCII test-pattern / display commands from the UART,
// holds them in shadow registers, commits them on frame strobes and returns a
// one-byte reply through the transmitter handshake.
module video_cmd_controller #(
    parameter int unsigned TIMEOUT_CYCLES = 2500000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_rx_byte,
    input  logic       i_rx_valid,
    input  logic       i_frame_strobe,
    input  logic       i_tx_active,
    input  logic       i_tx_done,
    output logic [7:0] o_tx_byte,
    output logic       o_tx_dv,
    output logic [3:0] o_pattern,
    output logic [7:0] o_display_byte,
    output logic       o_pending,
    output logic       o_resp_drop
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StGetP, StGetD1, StGetD2} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q;
    logic [3:0]      hi_q;
    logic [3:0]      shadow_pat_q;
    logic [7:0]      shadow_disp_q;
    logic [3:0]      pattern_q;
    logic [7:0]      display_q;
    logic            pending_q;
    logic [7:0]      slot_q;
    logic            slot_full_q;
    logic            tx_wait_q;
    logic            tx_dv_q;
    logic [7:0]      tx_byte_q;
    logic            resp_drop_q;

    // Parser decisions for this cycle
    logic       rply_req;
    logic [7:0] rply_byte;
    logic       pat_wr;
    logic       disp_wr;
    logic       hi_wr;
    logic       timeout;
    logic [4:0] hex;       // {valid, nibble}
    logic [7:0] pat_char;

    // Handshake decisions for this cycle
    logic launch;
    logic accept;
    logic drop;

    function automatic logic [4:0] hex_decode(input logic [7:0] c);
        if (c >= "0" && c <= "9") begin
            return {1'b1, c[3:0]};
        end else if ((c >= "A" && c <= "F") || (c >= "a" && c <= "f")) begin
            return {1'b1, c[3:0] + 4'd9};
        end else begin
            return 5'd0;
        end
    endfunction

    // Parser state register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and parser actions; a timeout wins only when no byte arrives
    always_comb begin
        state_d   = state_q;
        rply_req  = 1'b0;
        rply_byte = "E";
        pat_wr    = 1'b0;
        disp_wr   = 1'b0;
        hi_wr     = 1'b0;
        hex       = hex_decode(i_rx_byte);
        pat_char  = (pattern_q < 4'd10) ? (8'h30 + {4'h0, pattern_q})
                                        : (8'h37 + {4'h0, pattern_q});
        timeout   = (state_q != StIdle) && !i_rx_valid && (cnt_q == CntMax);
        if (timeout) begin
            state_d   = StIdle;
            rply_req  = 1'b1;
            rply_byte = "T";
        end else if (i_rx_valid) begin
            case (state_q)
                StIdle: begin
                    if (i_rx_byte == "P" || i_rx_byte == "p") begin
                        state_d = StGetP;
                    end else if (i_rx_byte == "D" || i_rx_byte == "d") begin
                        state_d = StGetD1;
                    end else if (i_rx_byte == "?") begin
                        rply_req  = 1'b1;
                        rply_byte = pat_char;
                    end else if (i_rx_byte != 8'h0D && i_rx_byte != 8'h0A &&
                                 i_rx_byte != 8'h20) begin
                        rply_req = 1'b1;
                    end
                end
                StGetP: begin
                    state_d  = StIdle;
                    rply_req = 1'b1;
                    if (hex[4]) begin
                        pat_wr    = 1'b1;
                        rply_byte = "K";
                    end
                end
                StGetD1: begin
                    if (hex[4]) begin
                        hi_wr   = 1'b1;
                        state_d = StGetD2;
                    end else begin
                        state_d  = StIdle;
                        rply_req = 1'b1;
                    end
                end
                StGetD2: begin
                    state_d  = StIdle;
                    rply_req = 1'b1;
                    if (hex[4]) begin
                        disp_wr   = 1'b1;
                        rply_byte = "K";
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Reply slot / transmitter handshake decisions
    always_comb begin
        launch = slot_full_q && !tx_wait_q && !i_tx_active;
        accept = rply_req && !slot_full_q && !tx_wait_q;
        drop   = rply_req && !accept;
    end

    // Datapath: timeout counter, shadows, frame commit, reply slot, tx handshake
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q         <= '0;
            hi_q          <= 4'h0;
            shadow_pat_q  <= 4'h0;
            shadow_disp_q <= 8'h00;
            pattern_q     <= 4'h0;
            display_q     <= 8'h00;
            pending_q     <= 1'b0;
            slot_q        <= 8'h00;
            slot_full_q   <= 1'b0;
            tx_wait_q     <= 1'b0;
            tx_dv_q       <= 1'b0;
            tx_byte_q     <= 8'h00;
            resp_drop_q   <= 1'b0;
        end else begin
            if (i_rx_valid || state_q == StIdle) begin
                cnt_q <= '0;
            end else if (cnt_q != CntMax) begin
                cnt_q <= cnt_q + CntW'(1);
            end

            if (hi_wr) hi_q <= hex[3:0];
            if (pat_wr) shadow_pat_q <= hex[3:0];
            if (disp_wr) shadow_disp_q <= {hi_q, hex[3:0]};

            // Commit samples the shadow before any same-cycle write lands
            if (i_frame_strobe) begin
                pattern_q <= shadow_pat_q;
                display_q <= shadow_disp_q;
            end
            if (pat_wr || disp_wr) begin
                pending_q <= 1'b1;
            end else if (i_frame_strobe) begin
                pending_q <= 1'b0;
            end

            if (accept) begin
                slot_q      <= rply_byte;
                slot_full_q <= 1'b1;
            end else if (launch) begin
                slot_full_q <= 1'b0;
            end

            if (launch) begin
                tx_wait_q <= 1'b1;
                tx_byte_q <= slot_q;
            end else if (i_tx_done) begin
                tx_wait_q <= 1'b0;
            end
            tx_dv_q     <= launch;
            resp_drop_q <= drop;
        end
    end

    assign o_tx_byte      = tx_byte_q;
    assign o_tx_dv        = tx_dv_q;
    assign o_pattern      = pattern_q;
    assign o_display_byte = display_q;
    assign o_pending      = pending_q;
    assign o_resp_drop    = resp_drop_q;

endmodule

// File: tb/tb_video_cmd_controller.sv
// Directed bench for video_cmd_controller with a small transmitter model.
module tb_video_cmd_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       frame_strobe;
    logic       tx_active;
    logic       tx_done;
    logic [7:0] tx_byte;
    logic       tx_dv;
    logic [3:0] pattern;
    logic [7:0] display_byte;
    logic       pending;
    logic       resp_drop;

    logic       tx_busy;
    logic       tx_hold;
    logic [7:0] reply_q[$];
    int         total = 0;
    int         bad = 0;
    int         dv_cnt = 0;
    int         drop_cnt = 0;

    assign tx_active = tx_busy | tx_hold;

    video_cmd_controller #(.TIMEOUT_CYCLES(100)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_rx_byte     (rx_byte),
        .i_rx_valid    (rx_valid),
        .i_frame_strobe(frame_strobe),
        .i_tx_active   (tx_active),
        .i_tx_done     (tx_done),
        .o_tx_byte     (tx_byte),
        .o_tx_dv       (tx_dv),
        .o_pattern     (pattern),
        .o_display_byte(display_byte),
        .o_pending     (pending),
        .o_resp_drop   (resp_drop)
    );

    always #20 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Transmitter model: busy for a few cycles per byte, then a done pulse
    initial begin
        tx_busy = 1'b0;
        tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_dv) begin
                dv_cnt++;
                reply_q.push_back(tx_byte);
                tx_busy = 1'b1;
                repeat (3) @(negedge clk);
                tx_done = 1'b1;
                @(negedge clk);
                tx_done = 1'b0;
                tx_busy = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (resp_drop) drop_cnt++;
        end
    end

    // Called at a negedge; returns at the negedge after the sampling edge
    task automatic send_byte(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic strobe();
        frame_strobe = 1'b1;
        @(negedge clk);
        frame_strobe = 1'b0;
    endtask

    task automatic expect_reply(input string tag, input logic [7:0] exp);
        int n = 0;
        while (reply_q.size() == 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (reply_q.size() == 0) begin
            check_eq({tag, "_timeout"}, 32'd0, 32'd1);
        end else begin
            check_eq(tag, {24'h0, reply_q.pop_front()}, {24'h0, exp});
        end
        n = 0;
        while (tx_busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int d0;
        int r0;
        rst          = 1'b1;
        rx_byte      = 8'h00;
        rx_valid     = 1'b0;
        frame_strobe = 1'b0;
        tx_hold      = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_pattern", {28'h0, pattern}, 32'h0);
        check_eq("rst_display", {24'h0, display_byte}, 32'h0);
        check_eq("rst_pending", {31'h0, pending}, 32'h0);
        check_eq("rst_tx_dv", {31'h0, tx_dv}, 32'h0);
        check_eq("rst_tx_byte", {24'h0, tx_byte}, 32'h0);
        check_eq("rst_drop", {31'h0, resp_drop}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Query with pattern 0, then a display write
        send_byte("?");
        expect_reply("query0", "0");
        send_byte("D"); send_byte("3"); send_byte("c");
        check_eq("d_pending", {31'h0, pending}, 32'h1);
        expect_reply("d_ack", "K");
        check_eq("d_display_pre", {24'h0, display_byte}, 32'h0);

        // Pattern write and commit
        send_byte("P"); send_byte("5");
        expect_reply("p5_ack", "K");
        check_eq("p5_pre", {28'h0, pattern}, 32'h0);
        strobe();
        check_eq("p5_post", {28'h0, pattern}, 32'h5);
        check_eq("d_post", {24'h0, display_byte}, 32'h3C);
        check_eq("p5_pending", {31'h0, pending}, 32'h0);
        send_byte("?");
        expect_reply("query5", "5");

        // Query reports active, not shadow
        send_byte("P"); send_byte("9");
        expect_reply("p9_ack", "K");
        send_byte("?");
        expect_reply("query_active", "5");
        strobe();
        check_eq("p9_post", {28'h0, pattern}, 32'h9);

        // Bad hex digit: single 'E', shadow untouched
        d0 = dv_cnt;
        send_byte("P"); send_byte("z");
        expect_reply("pz_err", "E");
        repeat (10) @(negedge clk);
        check_eq("pz_one_reply", dv_cnt - d0, 32'd1);
        check_eq("pz_pending", {31'h0, pending}, 32'h0);
        strobe();
        check_eq("pz_pattern", {28'h0, pattern}, 32'h9);
        send_byte("X");
        expect_reply("x_err", "E");
        d0 = dv_cnt;
        send_byte(8'h0D); send_byte(8'h0A); send_byte(8'h20);
        repeat (10) @(negedge clk);
        check_eq("ws_silent", dv_cnt - d0, 32'd0);

        // Inter-byte timeout
        send_byte("D"); send_byte("4");
        repeat (50) @(negedge clk);
        check_eq("no_early_t", reply_q.size(), 32'd0);
        expect_reply("timeout", "T");
        send_byte("P"); send_byte("1");
        expect_reply("after_t_ack", "K");
        strobe();
        check_eq("after_t_pattern", {28'h0, pattern}, 32'h1);

        // Slot full while transmitter busy
        tx_hold = 1'b1;
        d0 = dv_cnt;
        r0 = drop_cnt;
        send_byte("P"); send_byte("1"); send_byte("P"); send_byte("2");
        repeat (10) @(negedge clk);
        check_eq("bp_drop", drop_cnt - r0, 32'd1);
        check_eq("bp_held", dv_cnt - d0, 32'd0);
        tx_hold = 1'b0;
        expect_reply("bp_ack", "K");
        repeat (10) @(negedge clk);
        check_eq("bp_one_sent", dv_cnt - d0, 32'd1);
        strobe();
        check_eq("bp_pattern", {28'h0, pattern}, 32'h2);

        // Shadow write coincident with frame strobe
        send_byte("P");
        rx_byte      = "7";
        rx_valid     = 1'b1;
        frame_strobe = 1'b1;
        @(negedge clk);
        rx_valid     = 1'b0;
        frame_strobe = 1'b0;
        check_eq("coin_pattern", {28'h0, pattern}, 32'h2);
        check_eq("coin_pending", {31'h0, pending}, 32'h1);
        expect_reply("coin_ack", "K");
        strobe();
        check_eq("coin_next", {28'h0, pattern}, 32'h7);
        check_eq("coin_clear", {31'h0, pending}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
